// File: rtl/nvm_pkg.sv
// Shared types and widths for the NVM read arbiter slice.
package nvm_pkg;

  localparam int unsigned NVM_ADDR_W = 5;
  localparam int unsigned NVM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/nvm_rr_arbiter.sv
// Combinational winner select: round-robin from ptr, or lowest index when
// NVM_ARB_FIXED_PRIO_EN is defined (the ptr port is then absent).
module nvm_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef NVM_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [PTR_W-1:0]   winner
);

  logic found;

`ifdef NVM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner_oh = '0;
    winner    = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[PTR_W'(i)]) begin
        found     = 1'b1;
        winner    = PTR_W'(i);
        winner_oh = NUM_REQ'(1) << i;
      end
    end
  end
`else
  int unsigned idx;

  // Scan starts at ptr and wraps, so the last winner is visited last.
  always_comb begin
    winner_oh = '0;
    winner    = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found     = 1'b1;
        winner    = PTR_W'(idx);
        winner_oh = NUM_REQ'(1) << idx;
      end
    end
  end
`endif

endmodule

// File: rtl/nvm_read_arbiter.sv
// Shares one serial NVM reader between NUM_REQ burst requesters.
// Build option: NVM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module nvm_read_arbiter
  import nvm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = NVM_ADDR_W,
  parameter int unsigned DATA_W  = NVM_DATA_W,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      rd_last,
  output logic                      nvm_read,
  output logic [ADDR_W-1:0]         nvm_addr,
  input  logic                      nvm_sdata
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    len_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   sreg;
  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win;

`ifdef NVM_ARB_FIXED_PRIO_EN
  nvm_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req),
    .winner_oh (win_oh),
    .winner    (win)
  );
`else
  logic [PTR_W-1:0] ptr;

  nvm_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .winner_oh (win_oh),
    .winner    (win)
  );
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
`ifndef NVM_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
      gnt      <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      rd_last  <= 1'b0;
      nvm_read <= 1'b0;
      nvm_addr <= '0;
      cur_addr <= '0;
      len_cnt  <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
    end else begin
      rd_valid <= '0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= win_oh;
            cur_addr <= req_addr[win*ADDR_W +: ADDR_W];
            len_cnt  <= req_len[win*LEN_W +: LEN_W];
`ifndef NVM_ARB_FIXED_PRIO_EN
            ptr      <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
`endif
            state    <= LOAD;
          end
        end
        LOAD: begin
          nvm_read <= 1'b1;
          nvm_addr <= cur_addr;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          sreg    <= {sreg[DATA_W-3:0], nvm_sdata};
          bit_cnt <= bit_cnt + 1'b1;
          // Advance one bit early so the reader's end-of-byte reload fetches the next address.
          if (bit_cnt == CNT_W'(DATA_W-2) && len_cnt != '0)
            nvm_addr <= nvm_addr + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W-1)) begin
            rd_data  <= {sreg, nvm_sdata};
            rd_valid <= gnt;
            rd_last  <= (len_cnt == '0);
            bit_cnt  <= '0;
            if (len_cnt != '0) begin
              len_cnt <= len_cnt - 1'b1;
            end else begin
              nvm_read <= 1'b0;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_read_arbiter.sv
// Self-checking bench: behavioural serial reader + 32-byte memory, burst-timeline reference model.
module tb_nvm_read_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          clr;
  logic [3:0]    req;
  logic [19:0]   req_addr;
  logic [15:0]   req_len;
  logic [3:0]    gnt;
  logic [7:0]    rd_data;
  logic [3:0]    rd_valid;
  logic          rd_last;
  logic          nvm_read;
  logic [4:0]    nvm_addr;
  logic          nvm_sdata;

  int errors = 0;
  int checks = 0;

  nvm_read_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(8), .LEN_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .gnt       (gnt),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .nvm_read  (nvm_read),
    .nvm_addr  (nvm_addr),
    .nvm_sdata (nvm_sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural NVM reader
  logic [7:0] mem [32];
  logic       rdr_busy = 1'b0;
  logic [7:0] rdr_byte = 8'h00;
  logic [2:0] rdr_idx  = 3'd0;

  initial for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h5A;

  assign nvm_sdata = rdr_busy ? rdr_byte[rdr_idx] : mem[nvm_addr][7];

  always @(posedge clk) begin
    if (nvm_read !== 1'b1) begin
      rdr_busy <= 1'b0;
    end else if (!rdr_busy) begin
      rdr_busy <= 1'b1;
      rdr_byte <= mem[nvm_addr];
      rdr_idx  <= 3'd6;
    end else if (rdr_idx == 3'd0) begin
      rdr_byte <= mem[nvm_addr];
      rdr_idx  <= 3'd7;
    end else begin
      rdr_idx <= rdr_idx - 3'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
`ifdef NVM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
`endif
    return 0;
  endfunction

  // Reference model: a burst of n bytes granted at edge k=0 holds gnt for k<2+8n,
  // drives read for 1<=k<=8n, and delivers byte j at edge k=9+8j.
  logic        s_clr;
  logic [3:0]  s_req;
  logic [19:0] s_addr;
  logic [15:0] s_len;
  bit          m_busy = 0;
  int          m_k, m_n, m_w, m_a, m_j;
  int          m_ptr = 0;
  logic [7:0]  m_data = 8'h00;
  logic [4:0]  m_naddr = 5'd0;
  logic [3:0]  e_gnt, e_valid;
  logic        e_read, e_last;

  initial begin
    forever begin
      @(posedge clk);
      s_clr  = clr;
      s_req  = req;
      s_addr = req_addr;
      s_len  = req_len;
      #1;
      if (s_clr) begin
        m_busy  = 0;
        m_ptr   = 0;
        m_data  = 8'h00;
        m_naddr = 5'd0;
      end else if (m_busy) begin
        m_k++;
        if (m_k == 2 + 8 * m_n) m_busy = 0;
      end else if (s_req != 4'd0) begin
        m_w    = pick(s_req, m_ptr);
        m_ptr  = (m_w + 1) % NR;
        m_busy = 1;
        m_k    = 0;
        m_n    = int'(s_len[m_w*4 +: 4]) + 1;
        m_a    = int'(s_addr[m_w*5 +: 5]);
      end
      e_gnt   = m_busy ? 4'(1 << m_w) : 4'd0;
      e_read  = m_busy && m_k >= 1 && m_k <= 8 * m_n;
      e_valid = 4'd0;
      e_last  = 1'b0;
      if (e_read) m_naddr = 5'((m_a + ((m_k / 8 < m_n - 1) ? m_k / 8 : m_n - 1)) % 32);
      if (m_busy && m_k >= 9 && (m_k - 1) % 8 == 0) begin
        m_j     = (m_k - 9) / 8;
        e_valid = 4'(1 << m_w);
        e_last  = (m_j == m_n - 1);
        m_data  = 8'((m_a + m_j) % 32) ^ 8'h5A;
      end
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rd_valid", 32'(rd_valid), 32'(e_valid));
      chk("rd_last", 32'(rd_last), 32'(e_last));
      chk("nvm_read", 32'(nvm_read), 32'(e_read));
      chk("nvm_addr", 32'(nvm_addr), 32'(m_naddr));
      chk("rd_data", 32'(rd_data), 32'(m_data));
    end
  end

  task automatic expect_byte(input string name, input int exp_wait, input logic [3:0] ev,
                             input logic [7:0] ed, input logic el);
    int waited = 0;
    while (waited < 200) begin
      @(negedge clk);
      waited++;
      if (rd_valid != 4'd0) break;
    end
    chk({name, "_wait"}, 32'(waited), 32'(exp_wait));
    chk({name, "_valid"}, 32'(rd_valid), 32'(ev));
    chk({name, "_data"}, 32'(rd_data), 32'(ed));
    chk({name, "_last"}, 32'(rd_last), 32'(el));
  endtask

  task automatic wait_gnt_low(input string name, input int exp_wait);
    int waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      waited++;
      if (gnt == 4'd0) break;
    end
    chk(name, 32'(waited), 32'(exp_wait));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt, rd_valid, rd_last, nvm_read, nvm_addr, rd_data});
  endfunction

  logic [3:0] exp_order [5];
  logic [3:0] prev_gnt;
  logic [3:0] seen_valid;
  int         waited, ngrant;

  initial begin
`ifdef NVM_ARB_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    clr = 1'b1; req = '0; req_addr = '0; req_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    // single byte from requester 0
    req[0] = 1'b1; req_addr[0 +: 5] = 5'd3; req_len[0 +: 4] = 4'd0;
    expect_byte("t1", 10, 4'b0001, 8'h59, 1'b1);
    req = '0;
    wait_gnt_low("t1_gnt_fall", 1);

    // three bytes wrapping 30,31,0
    req[1] = 1'b1; req_addr[5 +: 5] = 5'd30; req_len[4 +: 4] = 4'd2;
    expect_byte("t2_b0", 10, 4'b0010, 8'h44, 1'b0);
    req = '0;
    expect_byte("t2_b1", 8, 4'b0010, 8'h45, 1'b0);
    expect_byte("t2_b2", 8, 4'b0010, 8'h5A, 1'b1);
    wait_gnt_low("t2_gnt_fall", 1);

    // all four held: grant order and spacing
    clr = 1'b1;
    @(negedge clk);
    chk("t3_reset_outs", all_outs(), 32'd0);
    clr = 1'b0;
    req_len = '0;
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'(4 * i);
    req = 4'b1111;
    prev_gnt = gnt;
    waited = 0;
    ngrant = 0;
    while (ngrant < 5 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (prev_gnt == 4'd0 && gnt != 4'd0) begin
        chk("t3_order", 32'(gnt), 32'(exp_order[ngrant]));
        chk("t3_spacing", 32'(waited), (ngrant == 0) ? 32'd1 : 32'd11);
        ngrant++;
        waited = 0;
      end
      prev_gnt = gnt;
    end
    chk("t3_grants", 32'(ngrant), 32'd5);
    req = '0;
    wait_gnt_low("t3_end", 10);

    // clr in SHIFT with bit_cnt=4
    req[3] = 1'b1; req_addr[15 +: 5] = 5'd7; req_len[12 +: 4] = 4'd1;
    repeat (6) @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'b1000);
    clr = 1'b1;
    @(negedge clk);
    chk("t4_clr_outs", all_outs(), 32'd0);
    clr = 1'b0;
    req = '0;
    seen_valid = '0;
    repeat (12) begin
      @(negedge clk);
      seen_valid = seen_valid | rd_valid;
    end
    chk("t4_no_valid", 32'(seen_valid), 32'd0);
    req[2] = 1'b1; req_addr[10 +: 5] = 5'd16; req_len[8 +: 4] = 4'd0;
    expect_byte("t4_next", 10, 4'b0100, 8'h4A, 1'b1);
    req = '0;
    wait_gnt_low("t4_gnt_fall", 1);

    // req[2] dropped right after grant; requester 1 queued behind it
    req[2] = 1'b1; req_addr[10 +: 5] = 5'd5; req_len[8 +: 4] = 4'd3;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'b0100);
    req[2] = 1'b0;
    req[1] = 1'b1; req_addr[5 +: 5] = 5'd9; req_len[4 +: 4] = 4'd0;
    expect_byte("t5_b0", 9, 4'b0100, 8'h5F, 1'b0);
    expect_byte("t5_b1", 8, 4'b0100, 8'h5C, 1'b0);
    expect_byte("t5_b2", 8, 4'b0100, 8'h5D, 1'b0);
    expect_byte("t5_b3", 8, 4'b0100, 8'h52, 1'b1);
    expect_byte("t5_next", 11, 4'b0010, 8'h53, 1'b1);
    req = '0;
    wait_gnt_low("t5_gnt_fall", 1);

    // owner's addr/len changed mid-burst
    req[0] = 1'b1; req_addr[0 +: 5] = 5'd20; req_len[0 +: 4] = 4'd2;
    @(negedge clk);
    req_addr[0 +: 5] = 5'd0; req_len[0 +: 4] = 4'd15;
    expect_byte("t6_b0", 9, 4'b0001, 8'h4E, 1'b0);
    req = '0;
    expect_byte("t6_b1", 8, 4'b0001, 8'h4F, 1'b0);
    expect_byte("t6_b2", 8, 4'b0001, 8'h4C, 1'b1);
    wait_gnt_low("t6_gnt_fall", 1);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        req = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
          req_addr[i*5 +: 5] = 5'($urandom);
          req_len[i*4 +: 4]  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
        end
      end
      clr = ($urandom_range(0, 299) == 0);
    end
    clr = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
